// File: rtl/instruction_fetch.sv
// Fetch stage: drives the external program_counter, fetches from instruction
// memory over req/ack, and presents the word to decode over valid/ready.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_out_addr,
    output logic [ADDR_WIDTH-1:0] pc_in_addr,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    output logic                  fetch_error
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERROR} state_t;

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  timeout_cnt_reg, timeout_cnt_next;
    logic                  pend_valid_reg, pend_valid_next;
    logic [ADDR_WIDTH-1:0] pend_target_reg, pend_target_next;
    logic [DATA_WIDTH-1:0] instr_reg, instr_next;
    logic [ADDR_WIDTH-1:0] instr_pc_reg, instr_pc_next;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  req_next;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  misaligned;
    logic                  timeout_hit;

    // Jump outranks a simultaneous branch.
    assign redirect        = jump | branch_taken;
    assign redirect_target = jump ? jump_target : branch_target;
    assign misaligned      = |pc_out_addr[1:0];
    assign timeout_hit     = (timeout_cnt_reg == CNT_WIDTH'(TIMEOUT - 1));

    always_comb begin
        state_next       = state_reg;
        timeout_cnt_next = timeout_cnt_reg;
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        pc_next          = pc_out_addr;
        req_next         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    pc_next = redirect_target;
                end
                timeout_cnt_next = '0;
                state_next       = REQ;
            end
            REQ: begin
                if (misaligned) begin
                    timeout_cnt_next = '0;
                    pend_valid_next  = 1'b0;
                    state_next       = ERROR;
                end else begin
                    req_next = 1'b1;
                    if (imem_ack) begin
                        timeout_cnt_next = '0;
                        if (redirect || pend_valid_reg) begin
                            // Stale fetch: drop the data and restart at the target.
                            pc_next         = redirect ? redirect_target : pend_target_reg;
                            pend_valid_next = 1'b0;
                        end else begin
                            instr_next    = imem_rdata;
                            instr_pc_next = pc_out_addr;
                            state_next    = HOLD;
                        end
                    end else begin
                        if (redirect) begin
                            pend_valid_next  = 1'b1;
                            pend_target_next = redirect_target;
                        end
                        if (timeout_hit) begin
                            timeout_cnt_next = '0;
                            pend_valid_next  = 1'b0;
                            state_next       = ERROR;
                        end else begin
                            timeout_cnt_next = timeout_cnt_reg + CNT_WIDTH'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (instr_ready) begin
                    pc_next    = pc_out_addr + ADDR_WIDTH'(4);
                    state_next = REQ;
                end
            end
            default: begin
                state_next = ERROR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            timeout_cnt_reg <= '0;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            timeout_cnt_reg <= timeout_cnt_next;
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
        end
    end

    assign pc_in_addr  = reset ? RESET_ADDR : pc_next;
    assign imem_req    = req_next & ~reset;
    assign imem_addr   = pc_out_addr;
    assign instr_valid = (state_reg == HOLD);
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign fetch_error = (state_reg == ERROR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: plays program_counter, instruction memory and
// decode, checking every cycle against a transaction-level PC/memory model.
module tb_instruction_fetch;

    localparam int              AW     = 32;
    localparam int              DW     = 32;
    localparam int              TO     = 16;
    localparam logic [AW-1:0]   RST_PC = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_out_addr;
    logic [AW-1:0] pc_in_addr;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          fetch_error;

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [AW-1:0] exp_pc;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_ADDR (RST_PC),
        .TIMEOUT    (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_out_addr   (pc_out_addr),
        .pc_in_addr    (pc_in_addr),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .fetch_error   (fetch_error)
    );

    always #5 clock = ~clock;

    // Stand-in for the program_counter register.
    always @(posedge clock) pc_out_addr <= pc_in_addr;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h2008_0000 + a;
    endfunction

    function automatic logic [AW-1:0] rand_target();
        return AW'($urandom_range(0, 4095)) << 2;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h (pc %08h)", tag, got, exp, exp_pc);
        end
    endtask

    task automatic clear_inputs();
        reset         = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        branch_target = rand_target();
        jump_target   = rand_target();
        imem_ack      = 1'b0;
        imem_rdata    = $urandom;
        instr_ready   = 1'b0;
    endtask

    task automatic drive_redirect(input bit use_jump, input logic [AW-1:0] tgt, input logic [AW-1:0] decoy);
        if (use_jump) begin
            jump          = 1'b1;
            jump_target   = tgt;
            branch_taken  = 1'b1;
            branch_target = decoy;
        end else begin
            jump          = 1'b0;
            jump_target   = decoy;
            branch_taken  = 1'b1;
            branch_target = tgt;
        end
    endtask

    task automatic do_reset(input int cycles, input bit idle_redir, input bit use_jump, input logic [AW-1:0] tgt);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            clear_inputs();
            reset    = 1'b1;
            imem_ack = 1'b1;
            #1 check_val("rst_pc_in", pc_in_addr, RST_PC);
        end
        @(negedge clock);
        check_val("rst_valid", instr_valid, 0);
        check_val("rst_req", imem_req, 0);
        check_val("rst_err", fetch_error, 0);
        check_val("rst_instr", instr, 0);
        check_val("rst_instr_pc", instr_pc, 0);
        clear_inputs();
        imem_ack = 1'b1;
        exp_pc   = RST_PC;
        if (idle_redir) begin
            drive_redirect(use_jump, tgt, rand_target());
            exp_pc = tgt;
        end
        #1 check_val("idle_pc_in", pc_in_addr, exp_pc);
        $display("[TB] reset cycles=%0d first_pc=%08h", cycles, exp_pc);
    endtask

    // One instruction: lat wait cycles before ack, stall cycles of backpressure,
    // then accept (PC+4) or a redirect out of HOLD.
    task automatic fetch_one(input int lat, input int stall, input bit redir, input bit use_jump,
                             input logic [AW-1:0] tgt, input logic [AW-1:0] decoy);
        logic [AW-1:0] next_pc;
        next_pc = redir ? tgt : exp_pc + 32'd4;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clock);
            check_val("req", imem_req, 1);
            check_val("req_addr", imem_addr, exp_pc);
            check_val("req_valid", instr_valid, 0);
            check_val("req_err", fetch_error, 0);
            clear_inputs();
            instr_ready = 1'($urandom);
            if (c == lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(exp_pc);
            end
            #1 check_val("req_pc_in", pc_in_addr, exp_pc);
        end
        for (int c = 0; c <= stall; c++) begin
            @(negedge clock);
            check_val("hold_valid", instr_valid, 1);
            check_val("hold_instr", instr, mem_word(exp_pc));
            check_val("hold_instr_pc", instr_pc, exp_pc);
            check_val("hold_req", imem_req, 0);
            check_val("hold_err", fetch_error, 0);
            clear_inputs();
            imem_ack = 1'($urandom);
            if (c == stall) begin
                if (redir) begin
                    drive_redirect(use_jump, tgt, decoy);
                    instr_ready = 1'($urandom);
                end else begin
                    instr_ready = 1'b1;
                end
            end
            #1 check_val("hold_pc_in", pc_in_addr, (c == stall) ? next_pc : exp_pc);
        end
        $display("[TB] fetch pc=%08h instr=%08h lat=%0d stall=%0d next=%08h",
                 exp_pc, mem_word(exp_pc), lat, stall, next_pc);
        exp_pc = next_pc;
    endtask

    // Redirect during REQ: data of the in-flight fetch is dropped, last target wins.
    task automatic discard_one(input int lat, input logic [AW-1:0] tgt, input bit extra);
        logic [AW-1:0] pend;
        logic [AW-1:0] t;
        pend = tgt;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clock);
            check_val("dreq", imem_req, 1);
            check_val("dreq_addr", imem_addr, exp_pc);
            check_val("dreq_valid", instr_valid, 0);
            check_val("dreq_err", fetch_error, 0);
            clear_inputs();
            if (c == 0) begin
                drive_redirect(1'($urandom), tgt, rand_target());
            end else if (extra && $urandom_range(0, 1) == 1) begin
                t = rand_target();
                drive_redirect(1'($urandom), t, rand_target());
                pend = t;
            end
            if (c == lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(exp_pc);
            end
            #1 check_val("dreq_pc_in", pc_in_addr, (c == lat) ? pend : exp_pc);
        end
        $display("[TB] discard pc=%08h lat=%0d next=%08h", exp_pc, lat, pend);
        exp_pc = pend;
    endtask

    task automatic timeout_run();
        for (int c = 0; c < TO; c++) begin
            @(negedge clock);
            check_val("to_req", imem_req, 1);
            check_val("to_addr", imem_addr, exp_pc);
            check_val("to_err_early", fetch_error, 0);
            clear_inputs();
            #1 check_val("to_pc_in", pc_in_addr, exp_pc);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check_val("to_err", fetch_error, 1);
            check_val("to_req_drop", imem_req, 0);
            check_val("to_valid", instr_valid, 0);
            clear_inputs();
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            drive_redirect(1'($urandom), rand_target(), rand_target());
            #1 check_val("err_pc_held", pc_in_addr, exp_pc);
        end
        $display("[TB] timeout pc=%08h cycles=%0d", exp_pc, TO);
    endtask

    task automatic misalign_run();
        @(negedge clock);
        check_val("mis_req", imem_req, 0);
        check_val("mis_valid", instr_valid, 0);
        clear_inputs();
        imem_ack = 1'b1;
        #1 check_val("mis_pc_in", pc_in_addr, exp_pc);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check_val("mis_err", fetch_error, 1);
            check_val("mis_req_off", imem_req, 0);
            check_val("mis_valid_off", instr_valid, 0);
            clear_inputs();
            #1 check_val("mis_pc_held", pc_in_addr, exp_pc);
        end
        $display("[TB] misaligned pc=%08h", exp_pc);
    endtask

    initial begin
        int kind;
        clear_inputs();
        reset  = 1'b1;
        exp_pc = RST_PC;

        do_reset(2, 1'b0, 1'b0, '0);
        fetch_one(0, 0, 1'b0, 1'b0, '0, '0);                         // 0 -> 4
        fetch_one(3, 2, 1'b0, 1'b0, '0, '0);                         // 4 -> 8
        fetch_one(0, 1, 1'b1, 1'b1, 32'h40, 32'h80);                 // jump over branch
        fetch_one(1, 0, 1'b1, 1'b0, 32'h0C, rand_target());          // 0x40 -> 0xC
        discard_one(2, 32'h100, 1'b0);                               // REQ redirect at 0xC
        fetch_one(0, 0, 1'b0, 1'b0, '0, '0);                         // 0x100
        fetch_one(0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, rand_target());
        fetch_one(2, 0, 1'b0, 1'b0, '0, '0);                         // wraps to 0
        timeout_run();

        do_reset(2, 1'b0, 1'b0, '0);
        fetch_one(10, 0, 1'b0, 1'b0, '0, '0);
        fetch_one(TO - 1, 1, 1'b0, 1'b0, '0, '0);                    // ack on last allowed cycle
        do_reset(1, 1'b1, 1'b1, 32'h200);                            // redirect in IDLE

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2)
                discard_one($urandom_range(0, 3), rand_target(), 1'b1);
            else
                fetch_one($urandom_range(0, 4), $urandom_range(0, 3), (kind < 5),
                          1'($urandom), rand_target(), rand_target());
        end

        fetch_one(0, 0, 1'b1, 1'b0, 32'h42, rand_target());
        misalign_run();
        do_reset(2, 1'b0, 1'b0, '0);
        fetch_one(0, 0, 1'b0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
